// File: rtl/irq_defs.sv
// Shared definitions for the core-side interrupt controller: cause codes,
// mip/mie bit positions, FSM state encoding and the priority encoder.
package irq_defs;

    localparam logic [3:0] MSI_CODE = 4'd3;
    localparam logic [3:0] MTI_CODE = 4'd7;
    localparam logic [3:0] MEI_CODE = 4'd11;

    localparam int MSIP_BIT = 3;
    localparam int MTIP_BIT = 7;
    localparam int MEIP_BIT = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } irq_state_t;

    // External beats software beats timer.
    function automatic logic [3:0] prio_code(input logic mei, input logic msi, input logic mti);
        logic [3:0] code;
        code = 4'd0;
        if (mei)      code = MEI_CODE;
        else if (msi) code = MSI_CODE;
        else if (mti) code = MTI_CODE;
        return code;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for an asynchronous level input. The first stage is
// exposed so the owner can look one cycle ahead of the synchronized output.
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic stage1,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage1 <= 1'b0;
            q      <= 1'b0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Core-side interrupt controller: registers CLINT lines into mip, masks them,
// and offers one prioritized interrupt to the pipeline over req/ack.
module irq_ctrl
    import irq_defs::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            msip,
    input  logic            mtip,
    input  logic            meip,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] mie,
    input  logic            irq_ack,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_cause,
    output logic [XLEN-1:0] mip,
    output logic            wakeup
);

    logic            msip_q;
    logic            mtip_q;
    logic            meip_s1;
    logic            meip_q;
    logic [XLEN-1:0] mip_next;
    logic [XLEN-1:0] pend;
    logic [3:0]      new_code;
    logic            load_cause;
    irq_state_t      state;
    irq_state_t      next_state;

    irq_sync u_meip_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (meip),
        .stage1 (meip_s1),
        .q      (meip_q)
    );

    always_comb begin
        mip_next           = '0;
        mip_next[MSIP_BIT] = msip;
        mip_next[MTIP_BIT] = mtip;
        mip_next[MEIP_BIT] = meip_s1;
    end

    always_comb begin
        mip           = '0;
        mip[MSIP_BIT] = msip_q;
        mip[MTIP_BIT] = mtip_q;
        mip[MEIP_BIT] = meip_q;
    end

    // Wake-up looks at the value mip is about to take so WFI resumes in step with mip.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msip_q <= 1'b0;
            mtip_q <= 1'b0;
            wakeup <= 1'b0;
        end else begin
            msip_q <= msip;
            mtip_q <= mtip;
            wakeup <= |(mip_next & mie);
        end
    end

    assign pend     = mip & mie & {XLEN{mstatus_mie}};
    assign new_code = prio_code(pend[MEIP_BIT], pend[MSIP_BIT], pend[MTIP_BIT]);
    assign irq_req  = (state == REQ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The cause code equals the mip bit position, so it indexes pend directly.
    always_comb begin
        next_state = state;
        load_cause = 1'b0;
        case (state)
            IDLE: begin
                if (|pend) begin
                    next_state = REQ;
                    load_cause = 1'b1;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    next_state = HOLD;
                end else if (!pend[irq_cause[3:0]]) begin
                    next_state = IDLE;
                end
            end
            HOLD:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_cause <= '0;
        end else if (load_cause) begin
            irq_cause <= {1'b1, {(XLEN-5){1'b0}}, new_code};
        end
    end

endmodule
